// File: rtl/sr_chk_pkg.sv
// Shared types and SR encodings for the SR flip-flop response checker.
package sr_chk_pkg;

    typedef enum logic {
        ST_UNKNOWN = 1'b0,
        ST_TRACK   = 1'b1
    } state_t;

    // SR encodings, bit order {s, r}.
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_BAD  = 2'b11;

endpackage

// File: rtl/sr_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module sr_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
    localparam logic [W-1:0] CNT_ONE = W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/sr_ff_checker.sv
// Response checker for a gate-level SR flip-flop: reference model, one-cycle compare pipeline, counters.
// Define SR_CHK_QBAR_EN to also check qbar against the complement of the expected Q.
module sr_ff_checker
    import sr_chk_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qbar,
    output logic             mismatch,
    output logic             invalid_in,
    output logic             err_sticky,
    output logic             exp_q,
    output logic             exp_known,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] invalid_cnt
);

    state_t     state, state_nxt;
    logic       exp_q_nxt;
    logic       check_pend, check_pend_nxt;
    logic       q_err;
    logic       mismatch_nxt, invalid_nxt;
    logic [1:0] sr;

    assign sr = {s, r};

    // State register; exp_q and check_pend are the model's datapath state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_UNKNOWN;
            exp_q      <= 1'b0;
            check_pend <= 1'b0;
            mismatch   <= 1'b0;
            invalid_in <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            exp_q      <= exp_q_nxt;
            check_pend <= check_pend_nxt;
            mismatch   <= mismatch_nxt;
            invalid_in <= invalid_nxt;
            err_sticky <= err_sticky | mismatch_nxt | invalid_nxt;
        end
    end

    // Next-state: SR characteristic table, advanced only on enabled edges.
    always_comb begin
        state_nxt = state;
        exp_q_nxt = exp_q;
        if (en) begin
            case (sr)
                SR_SET: begin
                    state_nxt = ST_TRACK;
                    exp_q_nxt = 1'b1;
                end
                SR_RST: begin
                    state_nxt = ST_TRACK;
                    exp_q_nxt = 1'b0;
                end
                SR_BAD:  state_nxt = ST_UNKNOWN;
                default: state_nxt = state;
            endcase
        end
    end

    // Outputs: compare uses the exp_q registered at the previous enabled edge.
    always_comb begin
`ifdef SR_CHK_QBAR_EN
        q_err = (q != exp_q) | (qbar != ~exp_q);
`else
        q_err = (q != exp_q);
`endif
        check_pend_nxt = en ? (state_nxt == ST_TRACK) : check_pend;
        mismatch_nxt   = check_pend & q_err;
        invalid_nxt    = en & (sr == SR_BAD);
    end

    assign exp_known = (state == ST_TRACK);

    sr_sat_counter #(.W(CNT_W)) u_mismatch_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mismatch_nxt),
        .cnt   (mismatch_cnt)
    );

    sr_sat_counter #(.W(CNT_W)) u_invalid_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (invalid_nxt),
        .cnt   (invalid_cnt)
    );

`ifndef SR_CHK_QBAR_EN
    logic unused_qbar;
    assign unused_qbar = qbar;
`endif

endmodule

// File: tb/tb_sr_ff_checker.sv
// Directed bench for sr_ff_checker: vector table plus hand-written reset/saturation/qbar sequences.
module tb_sr_ff_checker;

    logic       clk;
    logic       rst_n;
    logic       en, s, r, q, qbar;
    logic       mismatch, invalid_in, err_sticky, exp_q, exp_known;
    logic [7:0] mismatch_cnt, invalid_cnt;
    logic       mismatch2, invalid_in2, err_sticky2, exp_q2, exp_known2;
    logic [1:0] mismatch_cnt2, invalid_cnt2;

    int n_total;
    int n_pass;

    sr_ff_checker #(.CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .s            (s),
        .r            (r),
        .q            (q),
        .qbar         (qbar),
        .mismatch     (mismatch),
        .invalid_in   (invalid_in),
        .err_sticky   (err_sticky),
        .exp_q        (exp_q),
        .exp_known    (exp_known),
        .mismatch_cnt (mismatch_cnt),
        .invalid_cnt  (invalid_cnt)
    );

    sr_ff_checker #(.CNT_W(2)) dut2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .s            (s),
        .r            (r),
        .q            (q),
        .qbar         (qbar),
        .mismatch     (mismatch2),
        .invalid_in   (invalid_in2),
        .err_sticky   (err_sticky2),
        .exp_q        (exp_q2),
        .exp_known    (exp_known2),
        .mismatch_cnt (mismatch_cnt2),
        .invalid_cnt  (invalid_cnt2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic s, r, q, en;
        logic e_exp_q, e_known, e_mm, e_inv, e_sticky;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // Drive one edge's inputs (qbar is the true complement), then sample 1 time unit after the edge.
    task automatic step(input logic ts, input logic tr, input logic tq, input logic ten);
        s = ts; r = tr; q = tq; qbar = ~tq; en = ten;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s = 1'b0; r = 1'b0; q = 1'b0; qbar = 1'b1; en = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n = 1'b0;
        s = 1'b0; r = 1'b0; q = 1'b0; qbar = 1'b1; en = 1'b0;

        //           s     r     q     en    exp_q known mm    inv   sticky
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_mismatch", {7'd0, mismatch}, 8'd0);
        check("rst_invalid", {7'd0, invalid_in}, 8'd0);
        check("rst_sticky", {7'd0, err_sticky}, 8'd0);
        check("rst_exp_q", {7'd0, exp_q}, 8'd0);
        check("rst_known", {7'd0, exp_known}, 8'd0);
        check("rst_mm_cnt", mismatch_cnt, 8'd0);
        check("rst_inv_cnt", invalid_cnt, 8'd0);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].s, vecs[i].r, vecs[i].q, vecs[i].en);
            check($sformatf("v%0d_exp_q", i), {7'd0, exp_q}, {7'd0, vecs[i].e_exp_q});
            check($sformatf("v%0d_known", i), {7'd0, exp_known}, {7'd0, vecs[i].e_known});
            check($sformatf("v%0d_mismatch", i), {7'd0, mismatch}, {7'd0, vecs[i].e_mm});
            check($sformatf("v%0d_invalid", i), {7'd0, invalid_in}, {7'd0, vecs[i].e_inv});
            check($sformatf("v%0d_sticky", i), {7'd0, err_sticky}, {7'd0, vecs[i].e_sticky});
        end
        check("tbl_mm_cnt", mismatch_cnt, 8'd1);
        check("tbl_inv_cnt", invalid_cnt, 8'd1);

        // Mid-run reset clears everything immediately and drops the pending compare
        step(1'b1, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sticky", {7'd0, err_sticky}, 8'd0);
        check("mid_rst_known", {7'd0, exp_known}, 8'd0);
        check("mid_rst_mm_cnt", mismatch_cnt, 8'd0);
        check("mid_rst_inv_cnt", invalid_cnt, 8'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("post_rst_no_cmp", {7'd0, mismatch}, 8'd0);
        check("post_rst_known", {7'd0, exp_known}, 8'd0);

        // Q stuck at 1 after a reset command
        do_reset();
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("stuck_e1_mm", {7'd0, mismatch}, 8'd0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("stuck_e2_mm", {7'd0, mismatch}, 8'd1);
        check("stuck_e2_cnt", mismatch_cnt, 8'd1);
        check("stuck_e2_sticky", {7'd0, err_sticky}, 8'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("stuck_e3_mm", {7'd0, mismatch}, 8'd0);
        check("stuck_e3_sticky", {7'd0, err_sticky}, 8'd1);
        // Mismatch and forbidden input at the same edge
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("both_mm", {7'd0, mismatch}, 8'd1);
        check("both_inv", {7'd0, invalid_in}, 8'd1);
        check("both_mm_cnt", mismatch_cnt, 8'd2);
        check("both_inv_cnt", invalid_cnt, 8'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("after_bad_no_cmp", {7'd0, mismatch}, 8'd0);
        check("after_bad_inv_clr", {7'd0, invalid_in}, 8'd0);

        // Five consecutive mismatches: 8-bit count reaches 5, 2-bit count saturates at 3
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_cnt8", mismatch_cnt, 8'd5);
        check("sat_cnt2", {6'd0, mismatch_cnt2}, 8'd3);
        check("sat_mm2", {7'd0, mismatch2}, 8'd1);

        // qbar equal to q while q itself is correct
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        s = 1'b0; r = 1'b0; q = 1'b1; qbar = 1'b1; en = 1'b1;
        @(posedge clk);
        #1;
`ifdef SR_CHK_QBAR_EN
        check("qbar_mm", {7'd0, mismatch}, 8'd1);
`else
        check("qbar_mm", {7'd0, mismatch}, 8'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
